// File: rtl/booth_divider.sv
// ============================================================================
// Module      : booth_divider
// Description : Sequential signed two's-complement divider. Operand
//               magnitudes are divided with a restoring shift/subtract loop,
//               one quotient bit per clock, then signs are re-applied.
//               Quotient truncates toward zero; remainder takes the sign of
//               the dividend. Divide-by-zero and MIN/-1 are flagged.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK         in   1      system clock, rising edge
//   RST_N       in   1      asynchronous active-low reset
//   start       in   1      request pulse, sampled only while idle
//   dividend    in   WIDTH  signed dividend, captured on accept
//   divisor     in   WIDTH  signed divisor, captured on accept
//   busy        out  1      operation in progress
//   tx          out  1      one-cycle strobe: results newly updated
//   quotient    out  WIDTH  signed quotient
//   remainder   out  WIDTH  signed remainder
//   div_by_zero out  1      last result had divisor == 0
//   overflow    out  1      last result was MIN / -1
// ============================================================================
`default_nettype none

module booth_divider #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             tx,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
  localparam logic [CW-1:0]    c_cnt_one  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    c_last     = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dvz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_dvd_raw;
  // Holds the dividend magnitude; quotient bits shift in from the bottom, so
  // after the last iteration it holds the quotient magnitude.
  logic [WIDTH-1:0] r_dvd_mag;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH:0]   r_prem;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;

  // Magnitude of MIN wraps back to MIN, which read as unsigned is 2^(WIDTH-1).
  assign w_dvd_abs = dividend[WIDTH-1] ? (~dividend + c_one) : dividend;
  assign w_dvs_abs = divisor[WIDTH-1]  ? (~divisor  + c_one) : divisor;

  // The partial remainder stays below the divisor magnitude (<= 2^(WIDTH-1)),
  // so the shifted value never reaches the top bit and w_diff's MSB is a
  // clean sign for the trial subtraction.
  assign w_shift = {r_prem, r_dvd_mag[WIDTH-1]};
  assign w_diff  = w_shift - {2'b00, r_dvs_mag};
  assign w_ge    = ~w_diff[WIDTH+1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_dvz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_dvd_raw   <= '0;
      r_dvd_mag   <= '0;
      r_dvs_mag   <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      tx          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          tx <= 1'b0;
          if (start) begin
            r_sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r  <= dividend[WIDTH-1];
            r_dvz     <= (divisor == '0);
            r_ovf     <= (dividend == c_min) && (divisor == c_all_ones);
            r_dvd_raw <= dividend;
            r_dvd_mag <= w_dvd_abs;
            r_dvs_mag <= w_dvs_abs;
            r_prem    <= '0;
            r_cnt     <= '0;
            busy      <= 1'b1;
            r_state   <= S_CALC;
          end
        end

        S_CALC: begin
          r_prem    <= w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          r_dvd_mag <= {r_dvd_mag[WIDTH-2:0], w_ge};
          r_cnt     <= r_cnt + c_cnt_one;
          if (r_cnt == c_last) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          // The magnitude path already yields the wrapped MIN quotient and a
          // zero remainder for MIN / -1; only the zero divisor is overridden.
          if (r_dvz) begin
            quotient  <= c_all_ones;
            remainder <= r_dvd_raw;
          end else begin
            quotient  <= r_sign_q ? (~r_dvd_mag + c_one) : r_dvd_mag;
            remainder <= r_sign_r ? (~r_prem[WIDTH-1:0] + c_one) : r_prem[WIDTH-1:0];
          end
          div_by_zero <= r_dvz;
          overflow    <= r_ovf;
          tx          <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none

module tb_booth_divider;

  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int LAT   = WIDTH + 1;
  localparam int MINV  = -(1 << (WIDTH - 1));

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             tx;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  booth_divider #(.WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .tx          (tx),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division (truncates toward zero,
  // remainder follows dividend) plus the two special cases.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output logic dz, output logic ov);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = -1;
      r  = a;
      dz = 1'b1;
    end else if (a == MINV && b == -1) begin
      q  = MINV;
      r  = 0;
      ov = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic issue(input int a, input int b);
    @(negedge CLK);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_tx(input int lat0, output int lat, output int busy_low);
    lat      = lat0;
    busy_low = 0;
    while (tx !== 1'b1 && lat < 30) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int q, r;
    logic dz, ov;
    model(a, b, q, r, dz, ov);
    chk({tag, " tx"}, tx, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " quotient"}, quotient, q & MASK);
    chk({tag, " remainder"}, remainder, r & MASK);
    chk({tag, " div_by_zero"}, div_by_zero, dz);
    chk({tag, " overflow"}, overflow, ov);
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int lat, bl;
    issue(a, b);
    wait_tx(0, lat, bl);
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " busy_gap"}, bl, 0);
    check_result(tag, a, b);
    @(posedge CLK);
    #1;
    chk({tag, " tx_drop"}, tx, 0);
  endtask

  task automatic check_invariant(input string tag, input int a, input int b);
    int sq, sr, ar, ab;
    sq = int'($signed(quotient));
    sr = int'($signed(remainder));
    if (b != 0 && !(a == MINV && b == -1)) begin
      ar = (sr < 0) ? -sr : sr;
      ab = (b < 0) ? -b : b;
      chk({tag, " q*d+r"}, (sq * b + sr) & MASK, a & MASK);
      chk({tag, " |r|<|d|"}, (ar < ab) ? 1 : 0, 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bl, seen_tx, seen_busy;
    int a, b, k;

    // Reset state
    RST_N = 1'b0;
    #23;
    chk("reset busy", busy, 0);
    chk("reset tx", tx, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    chk("reset overflow", overflow, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed sign, overflow and zero cases
    run_op("7/2", 7, 2);
    chk("7/2 literal q", quotient, 4'b0011);
    run_op("-7/2", -7, 2);
    chk("-7/2 literal q", quotient, 4'b1101);
    chk("-7/2 literal r", remainder, 4'b1111);
    run_op("7/-2", 7, -2);
    run_op("-7/-2", -7, -2);
    run_op("-8/-1", -8, -1);
    chk("-8/-1 literal q", quotient, 4'b1000);
    run_op("6/3", 6, 3);
    run_op("5/0", 5, 0);
    chk("5/0 literal r", remainder, 4'b0101);

    // Start while busy is ignored; inputs changing mid-operation have no effect
    issue(7, 2);
    @(posedge CLK);
    @(negedge CLK);
    dividend = WIDTH'(1);
    divisor  = WIDTH'(1);
    start    = 1'b1;
    @(posedge CLK);
    #1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    wait_tx(2, lat, bl);
    chk("ignored latency", lat, LAT);
    check_result("ignored 7/2", 7, 2);

    // Start on the tx cycle is accepted; next tx is WIDTH+2 cycles later
    dividend = WIDTH'(6);
    divisor  = WIDTH'(3);
    start    = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    chk("b2b tx_drop", tx, 0);
    chk("b2b busy", busy, 1);
    wait_tx(1, lat, bl);
    chk("b2b spacing", lat, LAT + 1);
    check_result("b2b 6/3", 6, 3);

    // Asynchronous reset mid-operation
    issue(7, 2);
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort tx", tx, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    chk("abort overflow", overflow, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    seen_tx   = 0;
    seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (tx === 1'b1) seen_tx++;
      if (busy === 1'b1) seen_busy++;
    end
    chk("abort no tx", seen_tx, 0);
    chk("abort no busy", seen_busy, 0);
    run_op("post-reset 7/2", 7, 2);

    // Exhaustive sweep of all operand pairs
    for (int x = MINV; x <= -MINV - 1; x++) begin
      for (int y = MINV; y <= -MINV - 1; y++) begin
        run_op($sformatf("sweep %0d/%0d", x, y), x, y);
        check_invariant($sformatf("sweep %0d/%0d", x, y), x, y);
      end
    end

    // Randomized operations with stray start pulses while busy
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, MASK)) + MINV;
      b = int'($urandom_range(0, MASK)) + MINV;
      k = int'($urandom_range(0, LAT - 2));
      issue(a, b);
      for (int i = 0; i < k; i++) begin
        @(posedge CLK);
        #1;
      end
      dividend = WIDTH'($urandom_range(0, MASK));
      divisor  = WIDTH'($urandom_range(0, MASK));
      start    = 1'b1;
      @(posedge CLK);
      #1;
      start = 1'b0;
      wait_tx(k + 1, lat, bl);
      chk($sformatf("rand %0d/%0d latency", a, b), lat, LAT);
      check_result($sformatf("rand %0d/%0d", a, b), a, b);
      check_invariant($sformatf("rand %0d/%0d", a, b), a, b);
      @(posedge CLK);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
